// File: rtl/immediate_decode_stage_pkg.sv
// Shared encodings for the immediate decode stage: immediate type codes,
// base opcodes and the skid-buffer state type.
package immediate_decode_stage_pkg;

  // The select port is 3 bits wide, so Z shares its code with I_UNSIGNED.
  // Both carry an immediate that is already zero-extended in OUT_IMM.
  typedef enum logic [2:0] {
    U_TYPE          = 3'd0,
    J_TYPE          = 3'd1,
    S_TYPE          = 3'd2,
    B_TYPE          = 3'd3,
    I_SIGNED_TYPE   = 3'd4,
    I_SHIFT_TYPE    = 3'd5,
    I_UNSIGNED_TYPE = 3'd6,
    NO_IMM          = 3'd7
  } imm_sel_e;

  localparam imm_sel_e Z_TYPE = I_UNSIGNED_TYPE;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational immediate decode: type from opcode/funct3, field assembly,
// sign/zero extension to XLEN and legality of opcode/shamt.
module imm_field_extract
  import immediate_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_sel_e        sel,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_u, imm_j, imm_b, imm_s, imm_i, imm_iu, imm_z;
  logic [XLEN-1:0] shamt_native, shamt_word;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_iu = XLEN'(instr[31:20]);
  assign imm_z  = XLEN'(instr[19:15]);

  assign shamt_native = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign shamt_word   = XLEN'(instr[24:20]);

  always_comb begin
    imm     = '0;
    sel     = NO_IMM;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin sel = U_TYPE; imm = imm_u; end
      OPC_JAL:            begin sel = J_TYPE; imm = imm_j; end
      OPC_BRANCH:         begin sel = B_TYPE; imm = imm_b; end
      OPC_STORE:          begin sel = S_TYPE; imm = imm_s; end
      OPC_LOAD, OPC_JALR: begin sel = I_SIGNED_TYPE; imm = imm_i; end
      OPC_OP_IMM: begin
        if (is_shift) begin
          sel     = I_SHIFT_TYPE;
          imm     = shamt_native;
          illegal = (XLEN == 32) && instr[25];
        end else if (funct3 == 3'b011) begin
          sel = I_UNSIGNED_TYPE;
          imm = imm_iu;
        end else begin
          sel = I_SIGNED_TYPE;
          imm = imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          sel     = I_SHIFT_TYPE;
          imm     = shamt_word;
          illegal = instr[25];
        end else if (funct3 == 3'b011) begin
          sel = I_UNSIGNED_TYPE;
          imm = imm_iu;
        end else begin
          sel = I_SIGNED_TYPE;
          imm = imm_i;
        end
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          sel = Z_TYPE;
          imm = imm_z;
        end
      end
      OPC_OP:  sel = NO_IMM;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate-generation stage: decode feeds a 2-entry skid buffer
// with valid/ready handshakes on both sides and a synchronous flush.
module immediate_decode_stage
  import immediate_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_INSTR,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_IMM,
  output logic [2:0]       OUT_IMM_SEL,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_ILLEGAL
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_sel_e         sel;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_sel_e        dec_sel;
  logic            dec_illegal;
  entry_t          dec, entry0, entry1;
  skid_state_e     state, state_next;
  logic            in_fire, out_fire, load0_in, load0_skid, load1;

  imm_field_extract #(.XLEN(XLEN)) u_extract (
    .instr   (IN_INSTR),
    .imm     (dec_imm),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign dec = '{imm: dec_imm, sel: dec_sel, tag: IN_TAG, illegal: dec_illegal};

  assign IN_READY  = (state != TWO);
  assign OUT_VALID = (state != EMPTY);
  assign in_fire   = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;

  always_comb begin
    state_next = state;
    load0_in   = 1'b0;
    load0_skid = 1'b0;
    load1      = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin state_next = ONE; load0_in = 1'b1; end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_next = TWO;
          load1      = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_next = EMPTY;
        end else if (in_fire && out_fire) begin
          load0_in = 1'b1;
        end
      end
      TWO: if (out_fire) begin state_next = ONE; load0_skid = 1'b1; end
      default: state_next = EMPTY;
    endcase
    // Flush overrides every handshake in the same cycle.
    if (FLUSH) begin
      state_next = EMPTY;
      load0_in   = 1'b0;
      load0_skid = 1'b0;
      load1      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= EMPTY;
      entry0 <= '{imm: '0, sel: NO_IMM, tag: '0, illegal: 1'b0};
      entry1 <= '{imm: '0, sel: NO_IMM, tag: '0, illegal: 1'b0};
    end else begin
      state <= state_next;
      if (load0_in)        entry0 <= dec;
      else if (load0_skid) entry0 <= entry1;
      if (load1)           entry1 <= dec;
    end
  end

  assign OUT_IMM     = entry0.imm;
  assign OUT_IMM_SEL = entry0.sel;
  assign OUT_TAG     = entry0.tag;
  assign OUT_ILLEGAL = entry0.illegal;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Scoreboarded bench for immediate_decode_stage, with XLEN=32 and XLEN=64
// instances sharing the same stimulus.
module tb_immediate_decode_stage;
  import immediate_decode_stage_pkg::*;

  typedef struct packed { logic [63:0] imm; logic [2:0] sel; logic ill; } ref_t;
  typedef struct packed { logic [63:0] imm; logic [2:0] sel; logic [31:0] tag; logic ill; } exp_t;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  logic [2:0] out_imm_sel;
  logic in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0] out_imm_sel64;

  int tests = 0;
  int fails = 0;
  int popped = 0;
  exp_t q[$];
  exp_t q64[$];

  immediate_decode_stage #(.XLEN(32), .TAG_W(32)) dut (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_INSTR(in_instr), .IN_TAG(in_tag), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_IMM(out_imm), .OUT_IMM_SEL(out_imm_sel), .OUT_TAG(out_tag), .OUT_ILLEGAL(out_illegal)
  );

  immediate_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
    .IN_INSTR(in_instr), .IN_TAG(in_tag), .OUT_VALID(out_valid64), .OUT_READY(out_ready),
    .OUT_IMM(out_imm64), .OUT_IMM_SEL(out_imm_sel64), .OUT_TAG(out_tag64), .OUT_ILLEGAL(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ref_t ref_decode(input logic [31:0] i, input bit x64);
    ref_t r;
    logic [2:0] f3;
    f3 = i[14:12];
    r.imm = '0; r.sel = NO_IMM; r.ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin r.sel = U_TYPE; r.imm = {{32{i[31]}}, i[31:12], 12'h000}; end
      7'h6f: begin r.sel = J_TYPE; r.imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h63: begin r.sel = B_TYPE; r.imm = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
      7'h23: begin r.sel = S_TYPE; r.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
      7'h03, 7'h67: begin r.sel = I_SIGNED_TYPE; r.imm = {{52{i[31]}}, i[31:20]}; end
      7'h13, 7'h1b: begin
        if (i[6:0] == 7'h1b && !x64) r.ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          r.sel = I_SHIFT_TYPE;
          if (x64 && i[6:0] == 7'h13) r.imm = {58'b0, i[25:20]};
          else begin r.imm = {59'b0, i[24:20]}; r.ill = i[25]; end
        end else if (f3 == 3'd3) begin r.sel = I_UNSIGNED_TYPE; r.imm = {52'b0, i[31:20]}; end
        else begin r.sel = I_SIGNED_TYPE; r.imm = {{52{i[31]}}, i[31:20]}; end
      end
      7'h73: if (i[14]) begin r.sel = Z_TYPE; r.imm = {59'b0, i[19:15]}; end
      7'h33: r.sel = NO_IMM;
      default: r.ill = 1'b1;
    endcase
    if (!x64) r.imm[63:32] = '0;
    return r;
  endfunction

  // One clock: scoreboard pop/push at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    exp_t e;
    ref_t r;
    @(negedge clk);
    if (rst_n) begin
      if (flush) begin
        q.delete(); q64.delete();
      end else begin
        if (out_valid && out_ready) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL sb32_extra: got tag=%h imm=%h, expected no output", out_tag, out_imm);
          end else begin
            e = q.pop_front();
            popped++;
            if ({out_imm, out_imm_sel, out_tag, out_illegal} !== {e.imm[31:0], e.sel, e.tag, e.ill}) begin
              fails++;
              $display("FAIL sb32: got imm=%h sel=%0d tag=%h ill=%b, expected imm=%h sel=%0d tag=%h ill=%b",
                       out_imm, out_imm_sel, out_tag, out_illegal, e.imm[31:0], e.sel, e.tag, e.ill);
            end
          end
        end
        if (out_valid64 && out_ready) begin
          tests++;
          if (q64.size() == 0) begin
            fails++;
            $display("FAIL sb64_extra: got tag=%h, expected no output", out_tag64);
          end else begin
            e = q64.pop_front();
            if ({out_imm64, out_imm_sel64, out_tag64, out_illegal64} !== {e.imm, e.sel, e.tag, e.ill}) begin
              fails++;
              $display("FAIL sb64: got imm=%h sel=%0d tag=%h ill=%b, expected imm=%h sel=%0d tag=%h ill=%b",
                       out_imm64, out_imm_sel64, out_tag64, out_illegal64, e.imm, e.sel, e.tag, e.ill);
            end
          end
        end
        if (in_valid && in_ready) begin
          r = ref_decode(in_instr, 1'b0);
          q.push_back('{imm: r.imm, sel: r.sel, tag: in_tag, ill: r.ill});
        end
        if (in_valid && in_ready64) begin
          r = ref_decode(in_instr, 1'b1);
          q64.push_back('{imm: r.imm, sel: r.sel, tag: in_tag, ill: r.ill});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hA5;
    tick();
    tick();
    tests++;
    if ({out_valid, out_imm, out_imm_sel, out_tag, out_illegal, in_ready} !== {1'b0, 32'h0, NO_IMM, 32'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset32: got v=%b imm=%h sel=%0d tag=%h ill=%b rdy=%b, expected 0/0/%0d/0/0/1",
               out_valid, out_imm, out_imm_sel, out_tag, out_illegal, in_ready, NO_IMM);
    end
    tests++;
    if ({out_valid64, out_imm64, out_imm_sel64, in_ready64} !== {1'b0, 64'h0, NO_IMM, 1'b1}) begin
      fails++;
      $display("FAIL reset64: got v=%b imm=%h sel=%0d rdy=%b, expected 0/0/%0d/1",
               out_valid64, out_imm64, out_imm_sel64, in_ready64, NO_IMM);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] v_instr [10];
    logic [31:0] v_imm32 [10];
    logic [63:0] v_imm64 [10];
    imm_sel_e    v_sel32 [10];
    imm_sel_e    v_sel64 [10];
    logic        v_ill32 [10];
    logic        v_ill64 [10];
    v_instr = '{32'hFFF00093, 32'hFFDFF0EF, 32'h3002D073, 32'h03F09093, 32'h12345037,
                32'hFFF0B093, 32'h002081B3, 32'hFFFFFFFF, 32'h0010009B, 32'hFE000EE3};
    v_imm32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h5, 32'h1F, 32'h12345000,
                32'hFFF, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC};
    v_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h5, 64'h3F, 64'h12345000,
                64'hFFF, 64'h0, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFC};
    v_sel32 = '{I_SIGNED_TYPE, J_TYPE, Z_TYPE, I_SHIFT_TYPE, U_TYPE,
                I_UNSIGNED_TYPE, NO_IMM, NO_IMM, NO_IMM, B_TYPE};
    v_sel64 = '{I_SIGNED_TYPE, J_TYPE, Z_TYPE, I_SHIFT_TYPE, U_TYPE,
                I_UNSIGNED_TYPE, NO_IMM, NO_IMM, I_SIGNED_TYPE, B_TYPE};
    v_ill32 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v_ill64 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_instr = v_instr[k]; in_tag = 32'h100 + k;
      tick();
      tests++;
      if ({out_valid, in_ready, out_imm, out_imm_sel, out_illegal, out_tag} !==
          {1'b1, 1'b1, v_imm32[k], v_sel32[k], v_ill32[k], 32'h100 + k}) begin
        fails++;
        $display("FAIL vec32[%0d] %h: got v=%b rdy=%b imm=%h sel=%0d ill=%b tag=%h, expected 1/1/%h/%0d/%b/%h",
                 k, v_instr[k], out_valid, in_ready, out_imm, out_imm_sel, out_illegal, out_tag,
                 v_imm32[k], v_sel32[k], v_ill32[k], 32'h100 + k);
      end
      tests++;
      if ({out_valid64, out_imm64, out_imm_sel64, out_illegal64} !== {1'b1, v_imm64[k], v_sel64[k], v_ill64[k]}) begin
        fails++;
        $display("FAIL vec64[%0d] %h: got v=%b imm=%h sel=%0d ill=%b, expected 1/%h/%0d/%b",
                 k, v_instr[k], out_valid64, out_imm64, out_imm_sel64, out_illegal64,
                 v_imm64[k], v_sel64[k], v_ill64[k]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int start;
    start = popped;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'd1;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one: got %b, expected 1", in_ready); end
    in_instr = 32'h00200093; in_tag = 32'd2;
    tick();
    in_instr = 32'h00300093; in_tag = 32'd3;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 32'd1}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b tag=%0d, expected rdy=0 v=1 tag=1", c, in_ready, out_valid, out_tag);
      end
      if (c < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({in_ready, out_tag} !== {1'b1, 32'd2}) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b tag=%0d, expected rdy=1 tag=2", in_ready, out_tag);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tests++;
    if (popped - start != 3 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d outputs with %0d left, expected 3 with 0 left", popped - start, q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 32'h11;
    tick();
    in_tag = 32'h12;
    tick();
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_two: got rdy=%b, expected 0", in_ready); end
    flush = 1'b1; out_ready = 1'b1; in_tag = 32'h13;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if ({out_valid, in_ready, out_valid64} !== 3'b010) begin
      fails++;
      $display("FAIL flush_empty: got v=%b rdy=%b v64=%b, expected 0/1/0", out_valid, in_ready, out_valid64);
    end
    in_valid = 1'b1; in_instr = 32'h3002D073; in_tag = 32'h14;
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out_tag} !== {1'b1, 32'h14}) begin
      fails++;
      $display("FAIL flush_resume: got v=%b tag=%h, expected 1/14", out_valid, out_tag);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] pool [12];
    logic [31:0] r;
    pool = '{7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h03, 7'h67, 7'h13, 7'h73, 7'h33, 7'h1b, 7'h7f};
    for (int c = 0; c < 60; c++) begin
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = {r[31:7], pool[$urandom_range(0, 11)]};
      in_tag    = 32'h200 + c;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    tests++;
    if (q.size() != 0 || q64.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rand_drain: got %0d/%0d pending v=%b, expected 0/0 pending v=0", q.size(), q64.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFDFF0EF; in_tag = 32'h31;
    tick();
    in_tag = 32'h32;
    tick();
    #2 rst_n = 1'b0;
    q.delete(); q64.delete();
    #1;
    tests++;
    if ({out_valid, out_imm, out_imm_sel, out_tag, out_illegal, in_ready} !== {1'b0, 32'h0, NO_IMM, 32'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid: got v=%b imm=%h sel=%0d tag=%h ill=%b rdy=%b, expected 0/0/%0d/0/0/1",
               out_valid, out_imm, out_imm_sel, out_tag, out_illegal, in_ready, NO_IMM);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_hold: got v=%b, expected 0", out_valid); end
    rst_n = 1'b1;
    in_instr = 32'h03F09093; in_tag = 32'h55;
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out_tag, out_imm, out_illegal} !== {1'b1, 32'h55, 32'h1F, 1'b1}) begin
      fails++;
      $display("FAIL rst_resume: got v=%b tag=%h imm=%h ill=%b, expected 1/55/1f/1", out_valid, out_tag, out_imm, out_illegal);
    end
    tick();
    tests++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_drain: got %0d pending v=%b, expected 0 pending v=0", q.size(), out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
